gray_counter_n: RTL
===================

# gray_counter_n

Parametrised, registered Gray-code counter. It is the sequential successor to the team's combinational binary-to-Gray converter: it counts up or down in binary and presents the binary and Gray values from the same register stage. It adds synchronous load (binary or Gray-coded), wrap or saturate mode, a terminal-count flag and a wrap pulse. It is the pointer and sequence source for CDC-safe FIFO pointers and position encoders in the CA designs.

## Interface
- `WIDTH`, default 4: counter width in bits (≥ 2).
- `WRAP`, default 1: 1 = modulo-2^WIDTH wrap; 0 = saturate at the end values.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  count enable; one step per cycle while high.
- `up`  in  1  direction; 1 = increment, 0 = decrement.
- `load`  in  1  synchronous load strobe.
- `load_gray`  in  1  1 = `load_val` is Gray-coded; 0 = binary.
- `load_val`  in  WIDTH  load value.
- `bin_out`  out  WIDTH  current count, binary, registered.
- `gray_out`  out  WIDTH  current count, Gray, registered.
- `tc`  out  1  terminal count: high when the count equals the end value in the current direction (all-ones if `up`=1, zero if `up`=0). Combinational from the state register and `up`.
- `wrap_p`  out  1  registered one-cycle pulse, set in the cycle after a wrap occurred.

## Operation
- Internal state: binary register `cnt`. `gray_out` is a separate register loaded with `nxt ^ (nxt >> 1)` in the same edge as `cnt <= nxt`. This keeps `gray_out` glitch-free and exactly matched to `bin_out`.
- Priority per rising edge: reset > load > en > hold.
- Reset (`rst_n`=0 at the edge): `cnt`=0, `gray_out`=0, `wrap_p`=0.
- Load: `nxt` = `load_val` if `load_gray`=0, else the Gray-to-binary conversion of `load_val`. Conversion rule: b[W-1]=g[W-1], b[i]=b[i+1]^g[i]. A load ignores `en` and never sets `wrap_p`. `wrap_p` is 0 in the cycle after a load.
- Count, `en`=1 and `up`=1: `nxt = cnt + 1` modulo 2^WIDTH.
  - At all-ones with `WRAP`=1: `nxt`=0 and `wrap_p` is 1 in the next cycle.
  - At all-ones with `WRAP`=0: `nxt`=all-ones (hold) and `wrap_p` stays 0.
- Count, `en`=1 and `up`=0: symmetric decrement. At 0, `WRAP`=1 gives all-ones plus `wrap_p`; `WRAP`=0 holds at 0.
- Hold (`en`=0, `load`=0): all registers keep their value and `wrap_p` is 0.
- A direction change takes effect on the next enabled edge. There is no pipeline to flush.
- Width rule: all arithmetic is WIDTH bits. There is no carry-out port; `wrap_p` is the only overflow indication.

## Timing
- Latency of 1 clock from `en`/`load` sampled to `bin_out`/`gray_out` update.
- `tc` follows `cnt` and `up` with no register delay. It is valid whenever the count is at the end value, regardless of `en`.
- `wrap_p` is high for exactly one cycle per wrap. Continuous counting with `WRAP`=1 and WIDTH=4 gives a pulse every 16 cycles.
- Reset mid-count: the next edge with `rst_n`=0 forces the reset values, even if `load` or `en` are high. Counting resumes on the first edge with `rst_n`=1.
- Successive `gray_out` values differ in exactly one bit for every enabled, non-saturated step, including the wrap step. This is the property downstream CDC logic depends on.

## Structure
- Shared package `gray_pkg`: functions `bin2gray(WIDTH)` and `gray2bin(WIDTH)`. The existing converter and its testbench switch to `bin2gray` so that all blocks share one encoding definition.
- One sub-module: `gray2bin` (combinational, parametrised WIDTH), used on the load path. It can be reused by CDC pointer synchronisers.
- The top contains the next-state mux, the `cnt`/`gray_out`/`wrap_p` registers and the `tc` logic.

## Test plan
- Reset then up-count (WIDTH=4, WRAP=1, `en`=1, `up`=1) for 17 cycles:
  - `bin_out` goes 0..15 then 0.
  - `gray_out` goes 0000, 0001, 0011, 0010, … 1000, 0000.
  - `wrap_p` is high for one cycle after 15→0.
  - Every step has a Hamming distance of 1.
- Down-count from reset (`up`=0): `bin_out` goes 0→15→14; `wrap_p` pulses once; `tc`=1 while `bin_out`=0.
- Saturate (WRAP=0): load binary 14, then count up 3 cycles. Required: `bin_out` 15, 15, 15; `gray_out`=1000; `wrap_p` never asserts; `tc`=1 from the first 15.
- Gray load: `load`=1, `load_gray`=1, `load_val`=1101. Required: next `bin_out`=9 (1001), `gray_out`=1101. With `load` and `en` both high, the load wins.
- Reset mid-operation: with the count at 7 and `en`=1, drive `rst_n`=0 for one edge together with `load`=1 and `load_val`=5. Required: outputs 0/0/0. After release, the count continues 1, 2, ….
- Hold: `en`=0 for 5 cycles at count 6. Required: `bin_out`=6, `gray_out`=0101, `wrap_p`=0 throughout.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray/binary encoding functions, operating on zero-extended MAXW-bit values
package gray_pkg;
   localparam int MAXW = 32;
   function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
      logic [MAXW-1:0] b;
      b[MAXW-1] = g[MAXW-1];
      for (int i = MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary converter, each binary bit is the XOR of all Gray bits at or above it
module gray2bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign o_bin[i] = ^i_gray[WIDTH-1:i];
   end
endmodule

// File: rtl/gray_counter_n.sv
// gray_counter_n: registered up/down Gray counter with binary/Gray load, wrap or saturate, tc and wrap pulse
module gray_counter_n
   import gray_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int WRAP  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic             load_gray,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             tc,
   output logic             wrap_p
);
   localparam bit WRAP_EN = WRAP != 0;
   logic [WIDTH-1:0] r_cnt, r_gray, w_load_bin, w_ld, w_nxt;
   logic             r_wrap, w_at_end;
   gray2bin #(.WIDTH(WIDTH)) u_g2b (
      .i_gray (load_val),
      .o_bin  (w_load_bin)
   );
   assign w_ld     = load_gray ? w_load_bin : load_val;
   assign w_at_end = up ? &r_cnt : ~|r_cnt;
   // saturation holds the end value; otherwise natural WIDTH-bit roll-over gives the wrap
   always_comb begin
      w_nxt = load ? w_ld :
              !en ? r_cnt :
              (w_at_end && !WRAP_EN) ? r_cnt :
              up ? r_cnt + 1'b1 : r_cnt - 1'b1;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_gray <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_cnt  <= w_nxt;
         r_gray <= WIDTH'(bin2gray(MAXW'(w_nxt)));
         r_wrap <= !load && en && w_at_end && WRAP_EN;
      end
   end
   assign bin_out  = r_cnt;
   assign gray_out = r_gray;
   assign tc       = w_at_end;
   assign wrap_p   = r_wrap;
endmodule
